// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH valid/ready stages, bubbles collapse, global freeze and flush.
// Optional occupancy output enabled by defining PIPE_REG_ELASTIC_COUNT_EN.

module pipe_reg_elastic_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             en,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  // Flush drops the valid bit only; the data register keeps its stale value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      if (load) begin
        valid <= 1'b1;
        q     <= d;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

module pipe_reg_elastic #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_REG_ELASTIC_COUNT_EN
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
`endif
  output logic [WIDTH-1:0] out_data
);
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            opn;
  logic [DEPTH-1:0]            load;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0][WIDTH-1:0] din;
  logic                        stage_en;
  logic                        in_xfer;
  logic                        out_xfer;

  // Ready ripples back from the output so a stall only reaches the first bubble.
  always_comb begin
    adv = '0;
    opn = '0;
    adv[DEPTH-1] = valid[DEPTH-1] & out_ready;
    opn[DEPTH-1] = ~valid[DEPTH-1] | adv[DEPTH-1];
    for (int i = DEPTH-2; i >= 0; i--) begin
      adv[i] = valid[i] & opn[i+1];
      opn[i] = ~valid[i] | adv[i];
    end
  end

  assign stage_en  = ena & ~flush;
  assign in_ready  = stage_en & opn[0];
  assign out_valid = ena & valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign load[g] = in_xfer;
      assign din[g]  = in_data;
    end else begin : g_body
      assign load[g] = adv[g-1];
      assign din[g]  = data[g-1];
    end
    pipe_reg_elastic_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .en    (stage_en),
      .load  (load[g]),
      .drain (adv[g]),
      .d     (din[g]),
      .valid (valid[g]),
      .q     (data[g])
    );
  end

`ifdef PIPE_REG_ELASTIC_COUNT_EN
  localparam int OCC_W = $clog2(DEPTH+1);
  // Tracks popcount(valid) by net transfers, so it moves on the same edge as the valid bits.
  always_ff @(posedge clk) begin
    if (rst || flush) occupancy <= '0;
    else if (stage_en) occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end
`endif
endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Randomized scoreboard bench for pipe_reg_elastic (WIDTH=8, DEPTH=3) with a position-list reference model.
module tb_pipe_reg_elastic;
  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef PIPE_REG_ELASTIC_COUNT_EN
  logic [$clog2(D+1)-1:0] occupancy;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sbq[$];
  int           pq[$];
  logic [W-1:0] dcur = '0;

  pipe_reg_elastic #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPE_REG_ELASTIC_COUNT_EN
    .occupancy (occupancy),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each in-flight item is a stage index; an item moves up one
  // stage unless blocked by the item ahead (after that item's own move).
  initial begin
    int  n, lim, np;
    bit  eir, eov;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n   = pq.size();
      eov = ena && n > 0 && pq[0] == D-1;
      eir = ena && !flush && (n < D || out_ready);
      chk("in_ready", {31'b0, in_ready}, {31'b0, eir});
      chk("out_valid", {31'b0, out_valid}, {31'b0, eov});
`ifdef PIPE_REG_ELASTIC_COUNT_EN
      chk("occupancy", 32'(occupancy), n);
`endif
      if (rst || flush) pq.delete();
      else if (ena) begin
        if (eov && out_ready) void'(pq.pop_front());
        lim = D-1;
        for (int k = 0; k < pq.size(); k++) begin
          np    = (pq[k] + 1 < lim) ? pq[k] + 1 : lim;
          pq[k] = np;
          lim   = np - 1;
        end
        if (in_valid && eir) begin
          pq.push_back(0);
          sbq.push_back(in_data);
        end
      end
    end
  end

  // Monitor: every output transfer must deliver the oldest outstanding item.
  initial begin
    logic [W-1:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data got %0h expected nothing (queue empty) at %0t", out_data, $time);
        end else begin
          e = sbq.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
      end
      if (rst || flush) sbq.delete();
    end
  end

  task automatic step(input bit iv, input bit ordy, input bit en, input bit fl, input bit r);
    in_valid  = iv;
    out_ready = ordy;
    ena       = en;
    flush     = fl;
    rst       = r;
    in_data   = dcur;
    @(negedge clk);
    if (iv && in_ready && !r) dcur++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("reset_out_data", 32'(out_data), 32'h0);

    dcur = 8'h01;
    repeat (5) step(1, 1, 1, 0, 0);
    repeat (4) step(0, 1, 1, 0, 0);

    dcur = 8'hA0;
    repeat (5) step(1, 0, 1, 0, 0);
    chk("bp_accepts", 32'(dcur), 32'hA3);
    repeat (2) step(1, 1, 1, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0);

    dcur = 8'h11;
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    dcur = 8'h22;
    repeat (4) step(1, 0, 1, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0);

    dcur = 8'h33;
    step(1, 0, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);

    dcur = 8'h50;
    repeat (3) step(1, 0, 1, 0, 0);
    dcur = 8'h77;
    step(1, 0, 1, 1, 0);
    chk("flush_no_accept", 32'(dcur), 32'h77);
    repeat (3) step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 1, 1, 0, 0);

    dcur = 8'h60;
    repeat (3) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 1);
    chk("rst_out_data", 32'(out_data), 32'h0);
    repeat (2) step(0, 1, 1, 0, 0);

    repeat (600) begin
      step($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 8 != 0,
           $urandom % 32 == 0, $urandom % 97 == 0);
      if ($urandom % 16 == 0) dcur = 8'($urandom);
    end

    repeat (8) step(0, 1, 1, 0, 0);
    chk("drain_scoreboard", sbq.size(), 0);
    chk("drain_model", pq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each stage with a valid bit, connected by a valid/ready handshake.
- Bubbles collapse, so a stall only backs up as far as the first empty stage.
- Provides a global enable (freeze) and a synchronous flush.
- Used between CPU pipeline stages (IF/ID, ID/EX, ...) and on bus paths where a plain enable register cannot absorb back-pressure.

Parameters:
- WIDTH, 8: data width in bits; must be 1 or more.
- DEPTH, 2: number of register stages; must be 1 or more.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- ena, input, 1: global enable, active-high; 0 freezes the whole block.
- flush, input, 1: synchronous flush, active-high; invalidates every stage.
- in_valid, input, 1: upstream has data.
- in_ready, output, 1: stage 0 can accept data this cycle.
- in_data, input, WIDTH: upstream data.
- out_valid, output, 1: last stage holds data.
- out_ready, input, 1: downstream accepts data.
- out_data, output, WIDTH: last-stage data.

Behaviour:
- Reset:
  - rst is sampled at the rising clk edge and has the highest priority.
  - It clears every valid[i] to 0 and every data[i] to 0.
  - After reset: out_valid=0, out_data=0, in_ready=1 (provided ena=1 and flush=0).
- Stage advance rule, evaluated combinationally from the last stage back to stage 0:
  - adv[DEPTH-1] = valid[DEPTH-1] & out_ready.
  - open[i] = !valid[i] | adv[i].
  - adv[i] = valid[i] & open[i+1], for i < DEPTH-1.
  - in_ready = ena & !flush & open[0].
  - out_valid = ena & valid[DEPTH-1].
  - out_data = data[DEPTH-1]; it is not gated.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Register update when ena=1 and flush=0, on each edge:
  - Stage 0 loads in_data and sets valid[0] on an input transfer. Otherwise valid[0] clears if adv[0], else it holds.
  - Stage i > 0 loads data[i-1] and sets valid[i] if adv[i-1]. Otherwise valid[i] clears if adv[i], else it holds.
  - A data register is written only when its stage loads. Empty stages keep stale data.
- Simultaneous events: a stage may drain and load in the same cycle. Full throughput is 1 item per cycle with out_ready held at 1.
- Latency: DEPTH cycles from an input transfer to out_valid, when no stage ahead is stalled.
- Back-pressure:
  - With out_ready=0, the pipeline fills.
  - in_ready drops only when all DEPTH stages are valid.
  - Exactly DEPTH items are accepted after out_ready falls from an empty pipeline.
- Enable:
  - ena=0: no register changes, in_ready=0, out_valid=0, and no transfer occurs on either side.
  - Contents are preserved and resume unchanged when ena returns to 1.
- Flush:
  - flush=1, regardless of ena, clears all valid bits on the edge. Data registers hold.
  - in_ready is forced to 0 in the flush cycle, so no input is accepted.
  - out_valid may still be 1 in the flush cycle. If out_ready=1 in that cycle, the output transfer counts as completed (downstream consumed it); the item is not replayed.
- Priority: rst > flush > ena.
- Reset mid-operation: all in-flight items are dropped, and the block is ready on the next cycle.
- DEPTH=1 degenerates to a single full-throughput register stage. in_ready = ena & !flush & (!valid[0] | out_ready).

Optional Feature:
- Macro: PIPE_REG_ELASTIC_COUNT_EN.
- When defined:
  - Adds output port occupancy, width $clog2(DEPTH+1), equal to the number of valid stages.
  - It is registered and updated consistently with the valid bits.
  - It resets to 0 and goes to 0 on flush.
  - Its value always equals the popcount of valid[] after each edge.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=3):
- Reset, then stream 0x01..0x05 with in_valid=1, out_ready=1, ena=1 -> first out_valid at cycle 3 after the first accept, then 0x01..0x05 on consecutive cycles, in_ready held at 1 throughout.
- out_ready=0, in_valid=1 with data 0xA0.. -> exactly 3 accepts (0xA0, 0xA1, 0xA2), then in_ready=0; raise out_ready -> 0xA0, 0xA1, 0xA2 emerge in order and in_ready returns to 1 the same cycle.
- Pipeline holding 0x11, 0x22 with a bubble between them, out_ready=0 -> the bubble collapses, 0x22 advances, and in_ready stays 1 until all 3 stages are valid.
- ena=0 for 4 cycles mid-stream holding 0x33 at the output -> out_valid=0 and in_ready=0 for all 4 cycles; after ena=1, 0x33 is presented with no loss or duplication.
- flush=1 with 3 valid items and in_valid=1 (0x77) -> next cycle out_valid=0, 0x77 not accepted; with PIPE_REG_ELASTIC_COUNT_EN, occupancy goes 3->0.
- rst=1 asserted while full and out_ready=1, with flush=1 also asserted -> next cycle out_valid=0, out_data=0x00, in_ready=1, occupancy=0.
